// File: rtl/portfifo_sched_pkg.sv
// Shared constants and types for the PORTFIFO occupancy tracker / read scheduler.
// Widths here describe the default configuration; the top derives its own from its parameters.
package portfifo_pkg;

  localparam int NUM_PORTS_DEF  = 16;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int FIFO_DEPTH_DEF = 64;
  localparam int MAX_BURST_DEF  = 8;

  localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH_DEF);
  localparam int CNT_WIDTH  = PTR_WIDTH + 1;
  localparam int PORT_WIDTH = $clog2(NUM_PORTS_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // A counter must hold 0..depth inclusive, hence one bit above the pointer width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/portfifo_sched_if.sv
// Bundle of the enqueue mirror, FIFO read control and downstream stream of portfifo_sched.
// Downstream stream: a word moves on a cycle where out_valid and out_ready are both high; once out_valid rises, out_valid, out_data and out_port hold until that transfer.
interface portfifo_sched_if #(
  parameter int NUM_PORTS  = 16,
  parameter int DATA_WIDTH = 64
);
  localparam int PW = $clog2(NUM_PORTS);

  logic [PW-1:0]         wrport_in;
  logic                  wrreq_in;
  logic [NUM_PORTS-1:0]  full_out;
  logic                  overflow_err_out;
  logic [PW-1:0]         rdport_out;
  logic                  rdreq_out;
  logic [DATA_WIDTH-1:0] fifo_q_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [PW-1:0]         out_port;

  modport master (
    input  wrport_in, wrreq_in, fifo_q_in, out_ready,
    output full_out, overflow_err_out, rdport_out, rdreq_out,
    output out_valid, out_data, out_port
  );

  modport slave (
    output wrport_in, wrreq_in, fifo_q_in, out_ready,
    input  full_out, overflow_err_out, rdport_out, rdreq_out,
    input  out_valid, out_data, out_port
  );

endinterface

// File: rtl/portfifo_sched_rr_arbiter.sv
// Combinational round-robin arbiter: highest priority goes to the port just after last_grant.
module rr_arbiter #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [N-1:0] grant_oh,
  output logic [W-1:0] grant,
  output logic         any_req
);

  logic [W-1:0] idx;

  // Scan from lowest to highest priority so the last hit written is the winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = last_grant + W'(k);
      if (req[idx]) grant = idx;
    end
    any_req  = |req;
    grant_oh = any_req ? (N'(1) << grant) : '0;
  end

endmodule

// File: rtl/portfifo_sched.sv
// Per-port occupancy counters mirroring PORTFIFO enqueues/pops, plus a round-robin burst
// read scheduler that streams popped words downstream tagged with their source port.
module portfifo_sched
  import portfifo_pkg::*;
#(
  parameter int NUM_PORTS  = NUM_PORTS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  portfifo_sched_if.master  bus,
  output state_t            state_dbg
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_t               state;
  logic [PW-1:0]        last_grant;
  logic [BW-1:0]        burst;
  logic [NUM_PORTS-1:0] served_oh;
  logic [CW-1:0]        count      [NUM_PORTS];
  logic [CW-1:0]        count_next [NUM_PORTS];
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant_oh;
  logic [PW-1:0]        grant;
  logic                 any_req;
  logic                 pop;
  logic                 ovf;

  rr_arbiter #(.N(NUM_PORTS), .W(PW)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant_oh   (grant_oh),
    .grant      (grant),
    .any_req    (any_req)
  );

  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.rdreq_out = pop;
  assign bus.out_data  = bus.fifo_q_in;
  assign bus.out_port  = bus.rdport_out;
  assign state_dbg     = state;
  assign ovf           = bus.wrreq_in && (count[bus.wrport_in] == DEPTH_C);

  // An enqueue into a full port is dropped from the count; the sticky error reports it.
  always_comb begin
    logic wr_hit;
    logic rd_hit;
    wr_hit = 1'b0;
    rd_hit = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_hit        = bus.wrreq_in && (bus.wrport_in == PW'(p));
      rd_hit        = pop && served_oh[p];
      count_next[p] = count[p];
      if (wr_hit && !rd_hit && (count[p] != DEPTH_C)) count_next[p] = count[p] + CW'(1);
      else if (rd_hit && !wr_hit)                     count_next[p] = count[p] - CW'(1);
      req[p] = (count[p] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) count[p] <= '0;
      bus.full_out         <= '0;
      bus.overflow_err_out <= 1'b0;
      bus.rdport_out       <= '0;
      bus.out_valid        <= 1'b0;
      served_oh            <= NUM_PORTS'(1);
      last_grant           <= PW'(NUM_PORTS - 1);
      burst                <= '0;
      state                <= IDLE;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        count[p]        <= count_next[p];
        bus.full_out[p] <= (count_next[p] == DEPTH_C);
      end
      if (ovf) bus.overflow_err_out <= 1'b1;

      case (state)
        IDLE: begin
          if (any_req) begin
            bus.rdport_out <= grant;
            served_oh      <= grant_oh;
            last_grant     <= grant;
            burst          <= '0;
            state          <= LOAD;
          end
        end
        LOAD: begin
          bus.out_valid <= 1'b1;
          state         <= PRESENT;
        end
        PRESENT: begin
          // Continuing needs a second committed word; a count of 1 could be racing its own write.
          if (bus.out_ready) begin
            if ((count[bus.rdport_out] >= CW'(2)) && (burst < BURST_LAST)) begin
              burst <= burst + BW'(1);
            end else begin
              bus.out_valid <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_portfifo_sched.sv
// Bench for portfifo_sched: behavioural PORTFIFO, per-port word model with round-robin burst planning.
module tb_portfifo_sched;
  import portfifo_pkg::*;

  localparam int NP    = 16;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << (CNT_WIDTH - 1);
  localparam int MB    = 8;
  localparam int GW    = PORT_WIDTH + DW;
  localparam int EW    = 1 + GW;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  portfifo_sched_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

  portfifo_sched #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Behavioural PORTFIFO: one-cycle registered read of the head of rdport_out.
  logic [DW-1:0]        fmem [NP][DEPTH];
  logic [PTR_WIDTH-1:0] wptr [NP];
  logic [PTR_WIDTH-1:0] rptr [NP];
  logic [DW-1:0]        wr_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        wptr[p] <= '0;
        rptr[p] <= '0;
      end
      bus.fifo_q_in <= '0;
    end else begin
      if (bus.wrreq_in) begin
        fmem[bus.wrport_in][wptr[bus.wrport_in]] <= wr_data;
        wptr[bus.wrport_in] <= wptr[bus.wrport_in] + 1'b1;
      end
      if (bus.rdreq_out) begin
        rptr[bus.rdport_out] <= rptr[bus.rdport_out] + 1'b1;
        bus.fifo_q_in <= fmem[bus.rdport_out][rptr[bus.rdport_out] + 1'b1];
      end else begin
        bus.fifo_q_in <= fmem[bus.rdport_out][rptr[bus.rdport_out]];
      end
    end
  end

  // Accepted downstream words with their cycle stamps.
  logic [GW-1:0] got_q [$];
  int            got_cyc [$];

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got_q.push_back({bus.out_port, bus.out_data});
      got_cyc.push_back(cyc);
    end
  end

  // Reference model: per-port pending counts, burst plan as {first_of_burst, port, data}.
  logic [EW-1:0] exp_q [$];
  int            pend [NP];
  int            enq_idx [NP];
  int            deq_idx [NP];
  logic [31:0]   salt;

  function automatic logic [DW-1:0] mk_data(input int p, input int i);
    return {salt, 8'(p), 24'(i)};
  endfunction

  task automatic plan_service(input int first_port);
    int  last;
    int  p;
    int  n;
    bit  any;
    last = (first_port + NP - 1) % NP;
    any  = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        p = (last + k) % NP;
        if (pend[p] > 0) begin
          n = (pend[p] < MB) ? pend[p] : MB;
          for (int j = 0; j < n; j++) begin
            exp_q.push_back({1'(j == 0), PORT_WIDTH'(p), mk_data(p, deq_idx[p])});
            deq_idx[p]++;
          end
          pend[p] -= n;
          last = p;
          any  = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    bus.wrreq_in   = 1'b0;
    bus.wrport_in  = '0;
    bus.out_ready  = 1'b0;
    wr_data        = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int p = 0; p < NP; p++) begin
      pend[p]    = 0;
      enq_idx[p] = 0;
      deq_idx[p] = 0;
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    salt = $urandom;
  endtask

  task automatic enq(input int p);
    bus.wrreq_in  = 1'b1;
    bus.wrport_in = PORT_WIDTH'(p);
    wr_data       = mk_data(p, enq_idx[p]);
    enq_idx[p]++;
    pend[p]++;
    tick();
    bus.wrreq_in = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    repeat (6) tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.rdreq_out !== 1'b0) begin n_fail++; $display("FAIL reset_rdreq: got %b expected 0", bus.rdreq_out); end
    n_checks++; if (bus.rdport_out !== '0) begin n_fail++; $display("FAIL reset_rdport: got %0d expected 0", bus.rdport_out); end
    n_checks++; if (bus.full_out !== '0) begin n_fail++; $display("FAIL reset_full: got %h expected 0", bus.full_out); end
    n_checks++; if (bus.overflow_err_out !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow_err_out); end
    repeat (5) tick();
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_idle_words: got %0d expected 0", got_q.size()); end
  endtask

  // Three enqueues to port 5 on cycles 0..2 with the sink always ready.
  task automatic test_single_port();
    logic exp_v;
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wrreq_in  = (i < 3);
      bus.wrport_in = PORT_WIDTH'(5);
      wr_data       = mk_data(5, i);
      @(negedge clk);
      exp_v = (i >= 3) && (i <= 5);
      n_checks++; if (bus.out_valid !== exp_v) begin n_fail++; $display("FAIL single_valid c%0d: got %b expected %b", i, bus.out_valid, exp_v); end
      n_checks++; if (bus.rdreq_out !== exp_v) begin n_fail++; $display("FAIL single_rdreq c%0d: got %b expected %b", i, bus.rdreq_out, exp_v); end
      if (exp_v) begin
        n_checks++;
        if ({bus.out_port, bus.out_data} !== {PORT_WIDTH'(5), mk_data(5, i - 3)}) begin
          n_fail++; $display("FAIL single_word c%0d: got %0d/%h expected 5/%h", i, bus.out_port, bus.out_data, mk_data(5, i - 3));
        end
      end
      @(posedge clk);
      #1;
    end
    bus.wrreq_in = 1'b0;
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL single_end_state: got %0d expected %0d", state_dbg, IDLE); end
  endtask

  // Ten words each on ports 2 and 9, released together: bursts interleave round-robin.
  task automatic test_two_ports_burst();
    int gap_exp;
    apply_reset();
    for (int i = 0; i < 10; i++) enq(2);
    for (int i = 0; i < 10; i++) enq(9);
    plan_service(2);
    bus.out_ready = 1'b1;
    wait_words(exp_q.size(), 300);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i][GW-1:0]) begin n_fail++; $display("FAIL burst_word %0d: got %h expected %h", i, got_q[i], exp_q[i][GW-1:0]); end
      if (i > 0) begin
        gap_exp = exp_q[i][EW-1] ? 3 : 1;
        n_checks++;
        if (got_cyc[i] - got_cyc[i-1] != gap_exp) begin n_fail++; $display("FAIL burst_gap %0d: got %0d expected %0d", i, got_cyc[i] - got_cyc[i-1], gap_exp); end
      end
    end
  endtask

  // Single word on port 3 popped in the same cycle a second word is enqueued to port 3.
  task automatic test_same_cycle_enq_pop();
    logic [GW-1:0] w0;
    logic [GW-1:0] w1;
    apply_reset();
    enq(3);
    repeat (3) tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL race_presenting: got %b expected 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    bus.wrreq_in  = 1'b1;
    bus.wrport_in = PORT_WIDTH'(3);
    wr_data       = mk_data(3, 1);
    tick();
    bus.wrreq_in = 1'b0;
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL race_burst_end: got %0d expected %0d", state_dbg, IDLE); end
    wait_words(2, 20);
    w0 = {PORT_WIDTH'(3), mk_data(3, 0)};
    w1 = {PORT_WIDTH'(3), mk_data(3, 1)};
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL race_count: got %0d expected 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_checks++; if (got_q[0] !== w0) begin n_fail++; $display("FAIL race_word0: got %h expected %h", got_q[0], w0); end
      n_checks++; if (got_q[1] !== w1) begin n_fail++; $display("FAIL race_word1: got %h expected %h", got_q[1], w1); end
      n_checks++; if (got_cyc[1] - got_cyc[0] != 3) begin n_fail++; $display("FAIL race_gap: got %0d expected 3", got_cyc[1] - got_cyc[0]); end
    end
  endtask

  // Sink ready pattern 1,0,0,1 mid-burst: stalled word holds, nothing lost or repeated.
  task automatic test_stall();
    logic [3:0]    pat;
    logic          held_v;
    logic [GW-1:0] held;
    apply_reset();
    pat = 4'b1001;
    for (int i = 0; i < 5; i++) enq(11);
    plan_service(11);
    held_v = 1'b0;
    held   = '0;
    for (int i = 0; i < 30; i++) begin
      bus.out_ready = (i < 4) ? pat[i] : 1'b1;
      @(negedge clk);
      if (held_v) begin
        n_checks++;
        if ({bus.out_valid, bus.out_port, bus.out_data} !== {1'b1, held}) begin
          n_fail++; $display("FAIL stall_hold c%0d: got %b/%h expected 1/%h", i, bus.out_valid, {bus.out_port, bus.out_data}, held);
        end
      end
      held_v = bus.out_valid && !bus.out_ready;
      held   = {bus.out_port, bus.out_data};
      @(posedge clk);
      #1;
    end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i][GW-1:0]) begin n_fail++; $display("FAIL stall_word %0d: got %h expected %h", i, got_q[i], exp_q[i][GW-1:0]); end
    end
  endtask

  // Random ports/lengths/interleave, random sink backpressure.
  task automatic test_random_traffic();
    int            ports [3];
    int            left [3];
    int            first;
    int            k;
    int            c;
    logic          held_v;
    logic [GW-1:0] held;
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      ports[0] = $urandom_range(0, NP - 1);
      ports[1] = (ports[0] + $urandom_range(1, 5)) % NP;
      ports[2] = (ports[1] + $urandom_range(1, 5)) % NP;
      if (ports[2] == ports[0]) ports[2] = (ports[2] + 1) % NP;
      for (int j = 0; j < 3; j++) left[j] = $urandom_range(1, 20);
      first = -1;
      while (left[0] + left[1] + left[2] > 0) begin
        k = $urandom_range(0, 2);
        if (left[k] > 0) begin
          if (first < 0) first = ports[k];
          enq(ports[k]);
          left[k]--;
        end
      end
      plan_service(first);
      c = 0;
      held_v = 1'b0;
      held   = '0;
      while (got_q.size() < exp_q.size() && c < 800) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (held_v) begin
          n_checks++;
          if ({bus.out_valid, bus.out_port, bus.out_data} !== {1'b1, held}) begin
            n_fail++; $display("FAIL rand_hold it%0d: got %b/%h expected 1/%h", it, bus.out_valid, {bus.out_port, bus.out_data}, held);
          end
        end
        held_v = bus.out_valid && !bus.out_ready;
        held   = {bus.out_port, bus.out_data};
        @(posedge clk);
        #1;
        c++;
      end
      bus.out_ready = 1'b1;
      repeat (6) tick();
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count it%0d: got %0d expected %0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i][GW-1:0]) begin n_fail++; $display("FAIL rand_word it%0d #%0d: got %h expected %h", it, i, got_q[i], exp_q[i][GW-1:0]); end
      end
    end
  endtask

  // Fill port 0 to depth, then one more enqueue: full, sticky overflow, count saturates.
  task automatic test_fill_overflow();
    int bad_port;
    apply_reset();
    for (int i = 0; i < DEPTH - 1; i++) enq(0);
    n_checks++; if (bus.full_out !== '0) begin n_fail++; $display("FAIL fill_not_full: got %h expected 0", bus.full_out); end
    enq(0);
    n_checks++; if (bus.full_out !== NP'(1)) begin n_fail++; $display("FAIL fill_full: got %h expected 0001", bus.full_out); end
    n_checks++; if (bus.overflow_err_out !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf: got %b expected 0", bus.overflow_err_out); end
    enq(0);
    n_checks++; if (bus.overflow_err_out !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %b expected 1", bus.overflow_err_out); end
    n_checks++; if (bus.full_out !== NP'(1)) begin n_fail++; $display("FAIL fill_still_full: got %h expected 0001", bus.full_out); end
    bus.out_ready = 1'b1;
    wait_words(DEPTH, 400);
    n_checks++; if (got_q.size() != DEPTH) begin n_fail++; $display("FAIL fill_drain_count: got %0d expected %0d", got_q.size(), DEPTH); end
    bad_port = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i][GW-1:DW] != '0) bad_port++;
    n_checks++; if (bad_port != 0) begin n_fail++; $display("FAIL fill_ports: got %0d foreign words expected 0", bad_port); end
    n_checks++; if (bus.overflow_err_out !== 1'b1) begin n_fail++; $display("FAIL fill_ovf_sticky: got %b expected 1", bus.overflow_err_out); end
    n_checks++; if (bus.full_out !== '0) begin n_fail++; $display("FAIL fill_drained_full: got %h expected 0", bus.full_out); end
  endtask

  // Reset pulse in the middle of a burst: immediate reset values, then clean restart.
  task automatic test_reset_mid_burst();
    int c;
    int seen;
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) enq(7);
    c = 0;
    while (!bus.out_valid && c < 20) begin
      tick();
      c++;
    end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_reached_burst: got %b expected 1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.rdreq_out !== 1'b0) begin n_fail++; $display("FAIL mid_rdreq: got %b expected 0", bus.rdreq_out); end
    n_checks++; if (bus.rdport_out !== '0) begin n_fail++; $display("FAIL mid_rdport: got %0d expected 0", bus.rdport_out); end
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL mid_state: got %0d expected %0d", state_dbg, IDLE); end
    n_checks++; if (bus.full_out !== '0) begin n_fail++; $display("FAIL mid_full: got %h expected 0", bus.full_out); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    got_cyc.delete();
    for (int p = 0; p < NP; p++) begin
      pend[p]    = 0;
      enq_idx[p] = 0;
      deq_idx[p] = 0;
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
      @(posedge clk);
      #1;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_quiet: got %0d valid cycles expected 0", seen); end
    enq(4);
    enq(4);
    wait_words(2, 20);
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL mid_restart_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      n_checks++;
      if (got_q[i] !== {PORT_WIDTH'(4), mk_data(4, i)}) begin n_fail++; $display("FAIL mid_restart_word %0d: got %h expected %h", i, got_q[i], {PORT_WIDTH'(4), mk_data(4, i)}); end
    end
  endtask

  initial begin
    bus.wrreq_in  = 1'b0;
    bus.wrport_in = '0;
    bus.out_ready = 1'b0;
    wr_data       = '0;
    salt          = '0;
    test_reset();
    test_single_port();
    test_two_ports_burst();
    test_same_cycle_enq_pop();
    test_stall();
    test_random_traffic();
    test_fill_overflow();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
